// File: rtl/otter_fetch_stage.sv
// otter_fetch_stage
//   Instruction-fetch stage of the pipelined OTTER RV32I core. Holds the PC,
//   drives a synchronous instruction memory, tracks the single in-flight read
//   and registers the returned word into the IF/ID register for cu_decoder.
//
// Ports
//   CLK                 in   clock, rising edge
//   RST_N               in   asynchronous active-low reset
//   STALL               in   hold PC, in-flight slot and IF/ID register
//   PC_SOURCE[1:0]      in   0 sequential, 1 jalr, 2 branch, 3 jal (nonzero flushes)
//   JALR_TARGET[31:0]   in   jalr target address
//   BRANCH_TARGET[31:0] in   branch target address
//   JAL_TARGET[31:0]    in   jal target address
//   IMEM_ADDR[31:0]     out  fetch address (the PC register)
//   IMEM_RD_EN          out  instruction memory read enable
//   IMEM_DATA[31:0]     in   read data, valid the cycle after an enabled read
//   IR_FETCH_REG[31:0]  out  IF/ID instruction word
//   PC_FETCH_REG[31:0]  out  PC of IR_FETCH_REG
//   PC_PLUS4_FETCH_REG  out  PC_FETCH_REG + 4 (link value)
//   VALID_FETCH_REG     out  IF/ID entry holds a real instruction
module otter_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic [1:0]  PC_SOURCE,
  input  logic [31:0] JALR_TARGET,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] JAL_TARGET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_RD_EN,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] IR_FETCH_REG,
  output logic [31:0] PC_FETCH_REG,
  output logic [31:0] PC_PLUS4_FETCH_REG,
  output logic        VALID_FETCH_REG
);

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_JALR   = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_JAL    = 2'd3
  } pc_src_e;

  pc_src_e     pc_src;
  logic        redirect;
  logic [31:0] target;

  logic [31:0] pc;
  logic [31:0] f1_pc;
  logic        f1_valid;

  assign pc_src   = pc_src_e'(PC_SOURCE);
  assign redirect = (pc_src != SRC_SEQ);

  always_comb begin
    target = '0;
    case (pc_src)
      SRC_JALR:   target = JALR_TARGET;
      SRC_BRANCH: target = BRANCH_TARGET;
      SRC_JAL:    target = JAL_TARGET;
      default:    target = '0;
    endcase
  end

  assign IMEM_ADDR = pc;
  // A redirect must read even while stalled; the word it returns is then
  // discarded because the in-flight slot is invalidated on the same edge.
  assign IMEM_RD_EN = RST_N & (~STALL | redirect);

  assign PC_PLUS4_FETCH_REG = PC_FETCH_REG + 32'd4;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc              <= RESET_PC;
      f1_pc           <= '0;
      f1_valid        <= 1'b0;
      IR_FETCH_REG    <= NOP_INSTR;
      PC_FETCH_REG    <= '0;
      VALID_FETCH_REG <= 1'b0;
    end else if (redirect) begin
      pc              <= {target[31:2], 2'b00};
      f1_valid        <= 1'b0;
      IR_FETCH_REG    <= NOP_INSTR;
      VALID_FETCH_REG <= 1'b0;
    end else if (!STALL) begin
      pc              <= pc + 32'd4;
      f1_pc           <= pc;
      f1_valid        <= 1'b1;
      IR_FETCH_REG    <= f1_valid ? IMEM_DATA : NOP_INSTR;
      PC_FETCH_REG    <= f1_pc;
      VALID_FETCH_REG <= f1_valid;
    end
  end

endmodule

// File: tb/tb_otter_fetch_stage.sv
module tb_otter_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        STALL = 1'b0;
  logic [1:0]  PC_SOURCE = 2'd0;
  logic [31:0] JALR_TARGET = '0;
  logic [31:0] BRANCH_TARGET = '0;
  logic [31:0] JAL_TARGET = '0;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RD_EN;
  logic [31:0] IMEM_DATA = '0;
  logic [31:0] IR_FETCH_REG;
  logic [31:0] PC_FETCH_REG;
  logic [31:0] PC_PLUS4_FETCH_REG;
  logic        VALID_FETCH_REG;

  int unsigned checks = 0;
  int unsigned errors = 0;

  otter_fetch_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .CLK                (CLK),
    .RST_N              (RST_N),
    .STALL              (STALL),
    .PC_SOURCE          (PC_SOURCE),
    .JALR_TARGET        (JALR_TARGET),
    .BRANCH_TARGET      (BRANCH_TARGET),
    .JAL_TARGET         (JAL_TARGET),
    .IMEM_ADDR          (IMEM_ADDR),
    .IMEM_RD_EN         (IMEM_RD_EN),
    .IMEM_DATA          (IMEM_DATA),
    .IR_FETCH_REG       (IR_FETCH_REG),
    .PC_FETCH_REG       (PC_FETCH_REG),
    .PC_PLUS4_FETCH_REG (PC_PLUS4_FETCH_REG),
    .VALID_FETCH_REG    (VALID_FETCH_REG)
  );

  always #5 CLK = ~CLK;

  // Program image: word[i] = 0x00100093 + (i << 20), i = byte address / 4.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h0010_0093 + ((addr >> 2) << 20);
  endfunction

  // Synchronous instruction memory; output holds while the read enable is low.
  always @(posedge CLK) begin
    if (IMEM_RD_EN) IMEM_DATA <= mem_word(IMEM_ADDR);
  end

  // Reference model: fetch PC plus a queue of issued-but-undelivered fetches.
  // A fetch is delivered to IF/ID on the second advancing edge after issue;
  // a redirect throws away everything still in flight.
  logic [31:0] m_pc;
  logic [31:0] q_pcs[$];
  logic [31:0] exp_ir;
  logic [31:0] exp_pcf;
  logic        exp_valid;
  logic        pcf_known;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC;
    q_pcs.delete();
    exp_ir    = NOP_INSTR;
    exp_valid = 1'b0;
    exp_pcf   = 32'h0;
    pcf_known = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check32({tag, ".imem_addr"}, IMEM_ADDR, m_pc);
    check32({tag, ".ir"}, IR_FETCH_REG, exp_ir);
    check1({tag, ".valid"}, VALID_FETCH_REG, exp_valid);
    if (pcf_known) begin
      check32({tag, ".pc_fetch"}, PC_FETCH_REG, exp_pcf);
      check32({tag, ".pc_plus4"}, PC_PLUS4_FETCH_REG, exp_pcf + 32'd4);
    end
  endtask

  // One clock cycle with the given controls. Called #1 after a rising edge
  // (or at a falling edge right after reset release).
  task automatic cycle(input string tag, input logic s, input logic [1:0] src,
                       input logic [31:0] tgt);
    logic [31:0] p;
    STALL         = s;
    PC_SOURCE     = src;
    JALR_TARGET   = (src == 2'd1) ? tgt : $urandom;
    BRANCH_TARGET = (src == 2'd2) ? tgt : $urandom;
    JAL_TARGET    = (src == 2'd3) ? tgt : $urandom;
    #1;
    check1({tag, ".rd_en"}, IMEM_RD_EN, (!s) || (src != 2'd0));
    check32({tag, ".pre_addr"}, IMEM_ADDR, m_pc);
    @(posedge CLK);
    if (src != 2'd0) begin
      m_pc      = tgt & 32'hFFFF_FFFC;
      q_pcs.delete();
      exp_ir    = NOP_INSTR;
      exp_valid = 1'b0;
    end else if (!s) begin
      q_pcs.push_back(m_pc);
      m_pc = m_pc + 32'd4;
      if (q_pcs.size() > 1) begin
        p         = q_pcs.pop_front();
        exp_ir    = mem_word(p);
        exp_valid = 1'b1;
        exp_pcf   = p;
        pcf_known = 1'b1;
      end else begin
        exp_ir    = NOP_INSTR;
        exp_valid = 1'b0;
        pcf_known = 1'b0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  // Asserts reset partway through the current cycle, checks the immediate
  // reset values, then releases between edges.
  task automatic reset_pulse(input string tag);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    check1({tag, ".rd_en"}, IMEM_RD_EN, 1'b0);
    STALL     = 1'b0;
    PC_SOURCE = 2'd0;
    @(posedge CLK);
    #1;
    check_outputs({tag, "_held"});
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    logic        s;
    logic [1:0]  src;
    logic [31:0] tgt;

    model_reset();
    @(posedge CLK);
    #1;
    reset_pulse("reset");

    // Startup: E0 bubble, then PCs 0, 4, 8 at one per cycle.
    cycle("e0", 1'b0, 2'd0, 32'h0);
    cycle("e1", 1'b0, 2'd0, 32'h0);
    check32("e1.word0", IR_FETCH_REG, 32'h0010_0093);
    cycle("e2", 1'b0, 2'd0, 32'h0);
    cycle("e3", 1'b0, 2'd0, 32'h0);
    check32("e3.pc8", PC_FETCH_REG, 32'h8);

    // Three-cycle stall holding PC 8, then PC 12 follows.
    for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 2'd0, 32'h0);
    cycle("resume", 1'b0, 2'd0, 32'h0);
    check32("resume.pc12", PC_FETCH_REG, 32'hC);

    // Branch to 0x40: two bubbles then word[0x10].
    cycle("br", 1'b0, 2'd2, 32'h40);
    for (int i = 0; i < 4; i++) cycle("br_run", 1'b0, 2'd0, 32'h0);

    // Misaligned jalr is aligned down.
    cycle("jalr", 1'b0, 2'd1, 32'h103);
    check32("jalr.addr", IMEM_ADDR, 32'h100);
    for (int i = 0; i < 3; i++) cycle("jalr_run", 1'b0, 2'd0, 32'h0);

    // Stall and jal together: redirect wins.
    cycle("stall_jal", 1'b1, 2'd3, 32'h200);
    check32("stall_jal.addr", IMEM_ADDR, 32'h200);
    for (int i = 0; i < 3; i++) cycle("jal_run", 1'b0, 2'd0, 32'h0);

    // Address wrap at the top of the space.
    cycle("wrap_br", 1'b0, 2'd2, 32'hFFFF_FFFC);
    cycle("wrap1", 1'b0, 2'd0, 32'h0);
    check32("wrap1.addr", IMEM_ADDR, 32'h0);
    for (int i = 0; i < 3; i++) cycle("wrap_run", 1'b0, 2'd0, 32'h0);

    // Randomized mix of advance, stall and redirects.
    for (int i = 0; i < 300; i++) begin
      s   = ($urandom_range(0, 3) == 0);
      src = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      tgt = $urandom;
      cycle("rand", s, src, tgt);
    end

    // Reset in the middle of a stall, then refetch from RESET_PC.
    cycle("pre_rst", 1'b0, 2'd0, 32'h0);
    cycle("rst_stall", 1'b1, 2'd0, 32'h0);
    reset_pulse("mid_reset");
    for (int i = 0; i < 4; i++) cycle("refetch", 1'b0, 2'd0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
